// File: rtl/div_unit_pkg.sv
// Shared types for the sequential M-extension divider: operand bus, opcodes,
// functional-unit occupancy and divider FSM encoding, plus small operand helpers.
package div_unit_pkg;

    localparam int XLEN = 32;
    parameter int DIV_ITERATIONS = XLEN;

    typedef logic [XLEN-1:0] data_bus_t;

    typedef enum logic [1:0] {
        DIV_  = 2'b00,
        DIVU_ = 2'b01,
        REM_  = 2'b10,
        REMU_ = 2'b11
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PREPARE = 2'b01,
        DIVIDE  = 2'b10,
        RESTORE = 2'b11
    } div_fsm_e;

    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

    function automatic logic is_rem_op(input div_ops_e op);
        return (op == REM_) || (op == REMU_);
    endfunction

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic data_bus_t abs_val(input data_bus_t x, input logic neg_en);
        return (neg_en && x[XLEN-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the issue stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    logic      valid_i;
    data_bus_t dividend_i;
    data_bus_t divisor_i;
    div_ops_e  operation_i;
    data_bus_t result_o;
    logic      valid_o;
    logic      div_by_zero_o;
    fu_state_e fu_state_o;

    modport master (
        output valid_i, dividend_i, divisor_i, operation_i,
        input  result_o, valid_o, div_by_zero_o, fu_state_o
    );

    modport slave (
        input  valid_i, dividend_i, divisor_i, operation_i,
        output result_o, valid_o, div_by_zero_o, fu_state_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider: one quotient bit per cycle, with a
// single-cycle fast path for divide-by-zero and signed overflow.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    div_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_PREPARE = PREPARE;
    localparam logic [1:0] S_DIVIDE  = DIVIDE;
    localparam logic [1:0] S_RESTORE = RESTORE;

    logic [1:0]  state_r;
    logic [4:0]  cnt_r;
    logic [32:0] rem_r;
    data_bus_t   quo_r;
    data_bus_t   dividend_r;
    data_bus_t   divisor_r;
    div_ops_e    op_r;
    logic        q_neg_r;
    logic        r_neg_r;
    data_bus_t   result_r;
    logic        valid_r;
    logic        dbz_r;
    fu_state_e   fu_state_r;

    logic [32:0] shift_s;
    logic [33:0] diff_s;
    logic        zero_div_s;
    logic        ovf_s;
    data_bus_t   special_res_s;
    data_bus_t   final_res_s;

    // Trial subtraction; one extra bit so a 33-bit shifted remainder compares correctly against any divisor.
    always_comb begin
        shift_s = {rem_r[31:0], quo_r[XLEN-1]};
        diff_s  = {1'b0, shift_s} - {2'b00, divisor_r};
    end

    // Special-case detection and their architecturally fixed results.
    always_comb begin
        zero_div_s = (bus.divisor_i == 32'h0000_0000);
        ovf_s      = is_signed_op(bus.operation_i)
                     && (bus.dividend_i == 32'h8000_0000)
                     && (bus.divisor_i == 32'hFFFF_FFFF);
        if (zero_div_s) begin
            special_res_s = is_rem_op(bus.operation_i) ? bus.dividend_i : 32'hFFFF_FFFF;
        end else begin
            special_res_s = is_rem_op(bus.operation_i) ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // Sign fix-up of the selected magnitude at the end of the iterations.
    always_comb begin
        if (is_rem_op(op_r)) begin
            final_res_s = r_neg_r ? (~rem_r[31:0] + 32'd1) : rem_r[31:0];
        end else begin
            final_res_s = q_neg_r ? (~quo_r + 32'd1) : quo_r;
        end
    end

    // Divider FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= S_IDLE;
            cnt_r      <= 5'd0;
            rem_r      <= 33'd0;
            quo_r      <= 32'd0;
            dividend_r <= 32'd0;
            divisor_r  <= 32'd0;
            op_r       <= DIV_;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_r   <= 32'd0;
            valid_r    <= 1'b0;
            dbz_r      <= 1'b0;
            fu_state_r <= FREE;
        end else if (clear_i) begin
            state_r    <= S_IDLE;
            valid_r    <= 1'b0;
            dbz_r      <= 1'b0;
            fu_state_r <= FREE;
        end else begin
            valid_r <= 1'b0;
            dbz_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        op_r       <= bus.operation_i;
                        dividend_r <= bus.dividend_i;
                        divisor_r  <= bus.divisor_i;
                        if (zero_div_s || ovf_s) begin
                            result_r <= special_res_s;
                            valid_r  <= 1'b1;
                            dbz_r    <= zero_div_s;
                        end else begin
                            state_r    <= S_PREPARE;
                            fu_state_r <= BUSY;
                        end
                    end
                end
                S_PREPARE: begin
                    quo_r     <= abs_val(dividend_r, is_signed_op(op_r));
                    divisor_r <= abs_val(divisor_r, is_signed_op(op_r));
                    rem_r     <= 33'd0;
                    cnt_r     <= 5'd0;
                    q_neg_r   <= is_signed_op(op_r) & (dividend_r[XLEN-1] ^ divisor_r[XLEN-1]);
                    r_neg_r   <= is_signed_op(op_r) & dividend_r[XLEN-1];
                    state_r   <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    if (!diff_s[33]) begin
                        rem_r <= diff_s[32:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b1};
                    end else begin
                        rem_r <= shift_s;
                        quo_r <= {quo_r[XLEN-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(DIV_ITERATIONS - 1)) begin
                        state_r <= S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    result_r   <= final_res_s;
                    valid_r    <= 1'b1;
                    state_r    <= S_IDLE;
                    fu_state_r <= FREE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    fu_state_r <= FREE;
                end
            endcase
        end
    end

    assign bus.result_o      = result_r;
    assign bus.valid_o       = valid_r;
    assign bus.div_by_zero_o = dbz_r;
    assign bus.fu_state_o    = fu_state_r;

endmodule
